// File: rtl/store_buffer.sv
// Store buffer between commit and the data-memory write port: in-order FIFO drain
// with youngest-match load forwarding from all occupied entries.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [DATA_WIDTH-1:0]        st_data,
  output logic                         st_ready,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  output logic                         ld_hit,
  output logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         drain_stall,
  output logic                         mem_write_enable,
  output logic [ADDR_WIDTH-1:0]        mem_write_addr,
  output logic [DATA_WIDTH-1:0]        mem_write_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  enq;
  logic                  deq;

  assign empty    = (count == '0);
  assign st_ready = (count != FULL_CNT);
  assign enq      = st_valid && st_ready;
  // The memory must see no write while reset is discarding the contents.
  assign deq      = !empty && !drain_stall && !reset;

  assign mem_write_enable = deq;
  assign mem_write_addr   = empty ? '0 : addr_q[head];
  assign mem_write_data   = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand-written
// sequences for pointer wrap and youngest-match forwarding.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_hit, drain_stall;
  logic [31:0] ld_data;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr, mem_write_data;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .drain_stall(drain_stall),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic rst, sv; logic [31:0] sa, sd, la; logic ds;
    logic rdy; logic [2:0] cnt; logic emp, we; logic [31:0] wa, wd; logic hit; logic [31:0] ld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic sv, logic [31:0] sa, logic [31:0] sd,
                             logic [31:0] la, logic ds, logic rdy, logic [2:0] cnt,
                             logic emp, logic we, logic [31:0] wa, logic [31:0] wd,
                             logic hit, logic [31:0] ld);
    vec_t r;
    r.rst = rst; r.sv = sv; r.sa = sa; r.sd = sd; r.la = la; r.ds = ds;
    r.rdy = rdy; r.cnt = cnt; r.emp = emp; r.we = we; r.wa = wa; r.wd = wd;
    r.hit = hit; r.ld = ld;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [31:0] la, input logic ds);
    @(negedge clk);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd; ld_addr = la; drain_stall = ds;
    #1;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; drain_stall = 1'b0;
    repeat (2) @(negedge clk);

    //        rst sv  sa  sd   la  ds  rdy cnt emp we  wa  wd   hit ld
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 0, 0, 0,   0, 0,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 1, 8, 11,  8, 1,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 1, 8, 22,  8, 1,  1, 1, 0, 0,  8, 11,  1, 11));
    vecs.push_back(v(0, 1, 3, 33,  8, 1,  1, 2, 0, 0,  8, 11,  1, 22));
    vecs.push_back(v(0, 0, 0, 0,   8, 1,  1, 3, 0, 0,  8, 11,  1, 22));
    vecs.push_back(v(0, 0, 0, 0,   5, 1,  1, 3, 0, 0,  8, 11,  0, 0));
    vecs.push_back(v(0, 0, 0, 0,   3, 0,  1, 3, 0, 1,  8, 11,  1, 33));
    vecs.push_back(v(0, 0, 0, 0,   8, 0,  1, 2, 0, 1,  8, 22,  1, 22));
    vecs.push_back(v(0, 0, 0, 0,   3, 0,  1, 1, 0, 1,  3, 33,  1, 33));
    vecs.push_back(v(0, 0, 0, 0,   3, 0,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 1, 1, 101, 0, 1,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 1, 2, 102, 0, 1,  1, 1, 0, 0,  1, 101, 0, 0));
    vecs.push_back(v(0, 1, 3, 103, 0, 1,  1, 2, 0, 0,  1, 101, 0, 0));
    vecs.push_back(v(0, 1, 4, 104, 0, 1,  1, 3, 0, 0,  1, 101, 0, 0));
    vecs.push_back(v(0, 1, 5, 105, 5, 1,  0, 4, 0, 0,  1, 101, 0, 0));
    vecs.push_back(v(0, 1, 5, 105, 4, 1,  0, 4, 0, 0,  1, 101, 1, 104));
    vecs.push_back(v(0, 1, 5, 105, 0, 0,  0, 4, 0, 1,  1, 101, 0, 0));
    vecs.push_back(v(0, 1, 5, 105, 0, 1,  1, 3, 0, 0,  2, 102, 0, 0));
    vecs.push_back(v(0, 1, 6, 106, 5, 0,  0, 4, 0, 1,  2, 102, 1, 105));
    vecs.push_back(v(0, 1, 6, 106, 0, 0,  1, 3, 0, 1,  3, 103, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   6, 0,  1, 3, 0, 1,  4, 104, 1, 106));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,  1, 2, 0, 1,  5, 105, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,  1, 1, 0, 1,  6, 106, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   0, 0,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 1, 9, 44,  9, 1,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 0, 0, 0,   9, 1,  1, 1, 0, 0,  9, 44,  1, 44));
    vecs.push_back(v(0, 1, 20, 1,  9, 1,  1, 1, 0, 0,  9, 44,  1, 44));
    vecs.push_back(v(0, 1, 21, 2,  0, 1,  1, 2, 0, 0,  9, 44,  0, 0));
    vecs.push_back(v(1, 0, 0, 0,  21, 1,  1, 3, 0, 0,  9, 44,  1, 2));
    vecs.push_back(v(0, 0, 0, 0,   9, 0,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 0, 0, 0,  20, 0,  1, 0, 1, 0,  0, 0,   0, 0));
    vecs.push_back(v(0, 0, 0, 0,  21, 0,  1, 0, 1, 0,  0, 0,   0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].la, vecs[i].ds);
      check($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("v%0d write_enable", i), 32'(mem_write_enable), 32'(vecs[i].we));
      check($sformatf("v%0d write_addr", i), mem_write_addr, vecs[i].wa);
      check($sformatf("v%0d write_data", i), mem_write_data, vecs[i].wd);
      check($sformatf("v%0d ld_hit", i), 32'(ld_hit), 32'(vecs[i].hit));
      check($sformatf("v%0d ld_data", i), ld_data, vecs[i].ld);
    end

    // Streaming enqueue+drain every cycle: pointers wrap repeatedly, count holds at 1.
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 7, 200 + k, 7, 0);
      if (k == 0) begin
        check("stream first ld_hit", 32'(ld_hit), 0);
        check("stream first we", 32'(mem_write_enable), 0);
      end else begin
        check($sformatf("stream%0d count", k), 32'(count), 1);
        check($sformatf("stream%0d ld_data", k), ld_data, 200 + k - 1);
        check($sformatf("stream%0d we", k), 32'(mem_write_enable), 1);
        check($sformatf("stream%0d write_data", k), mem_write_data, 200 + k - 1);
      end
    end
    drive(0, 0, 0, 0, 7, 0);
    check("stream tail write_data", mem_write_data, 209);
    check("stream tail we", 32'(mem_write_enable), 1);
    begin
      int budget = 8;
      do begin
        drive(0, 0, 0, 0, 0, 0);
        budget--;
      end while (!empty && budget > 0);
      check("stream drained empty", 32'(empty), 1);
    end

    // Head now sits mid-array; fill across the wrap and check youngest-match.
    drive(0, 1, 7, 301, 0, 1);
    drive(0, 1, 7, 302, 0, 1);
    drive(0, 1, 8, 303, 0, 1);
    drive(0, 1, 7, 304, 7, 1);
    check("wrap same-cycle not forwarded", ld_data, 302);
    drive(0, 0, 0, 0, 7, 1);
    check("wrap full st_ready", 32'(st_ready), 0);
    check("wrap youngest addr7", ld_data, 304);
    drive(0, 0, 0, 0, 8, 0);
    check("wrap addr8 hit", ld_data, 303);
    check("wrap drain oldest", mem_write_data, 301);
    drive(0, 0, 0, 0, 7, 0);
    check("wrap second drain", mem_write_data, 302);
    check("wrap addr7 still youngest", ld_data, 304);
    drive(0, 0, 0, 0, 7, 1);
    check("wrap count after 2 drains", 32'(count), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
